// File: rtl/heater_pkg.sv
`default_nettype none
// ============================================================================
// Module      : heater_pkg
// Description : Shared types and helpers for the heater bank sequencer:
//               FSM state encoding and the active bank count width.
// Revision    : 1.0 - initial release
// ============================================================================
package heater_pkg;

    // Sequencer states, explicitly encoded so state values are stable in debug
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP_UP = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RUN     = 3'd3,
        ST_RAMP_DN = 3'd4,
        ST_FAULT   = 3'd5
    } heater_sched_state_t;

    // Width needed to hold a bank count from 0 to nbank inclusive
    function automatic int active_cnt_w(input int nbank);
        return (nbank < 1) ? 1 : $clog2(nbank + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/heater_pwm.sv
`default_nettype none
// ============================================================================
// Module      : heater_pwm
// Description : Free-running PWM counter with synchronous restart and a
//               duty compare. The gate reflects the count value the counter
//               is about to take, so a register fed from it lines up with
//               the counter after the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module heater_pwm #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [PWM_W-1:0] duty,
    output logic             gate
);

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] w_cnt_nxt;

    // Next count: restart forces zero, otherwise wrap-around increment
    always_comb begin
        w_cnt_nxt = restart ? '0 : r_cnt + 1'b1;
    end

    assign gate = (w_cnt_nxt < duty);

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/heater_sched.sv
`default_nettype none
// ============================================================================
// Module      : heater_sched
// Description : Sequencer for NBANK heater power-burn banks. Ramps bank
//               enables up one at a time, holds err_clear through a settle
//               window, optionally duty-cycles the banks in RUN, ramps down
//               on run drop and latches the first bank error into FAULT.
//               Optional feature macro: HEATER_SCHED_PWM_EN (PWM gating in
//               RUN; when undefined the duty input is ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module heater_sched
    import heater_pkg::*;
#(
    parameter int NBANK     = 4,
    parameter int RAMP_CYC  = 256,
    parameter int CLEAR_CYC = 2500,
    parameter int PWM_W     = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             run,
    input  logic [PWM_W-1:0]                 duty,
    input  logic                             fault_ack,
    input  logic [NBANK-1:0]                 bank_err,
    output logic [NBANK-1:0]                 bank_en,
    output logic                             err_clear,
    output logic                             busy,
    output logic                             fault,
    output logic [NBANK-1:0]                 fault_bank,
    output logic [active_cnt_w(NBANK)-1:0]   active_cnt
);

    localparam int c_CNT_W    = active_cnt_w(NBANK);
    localparam int c_STEP_MAX = (RAMP_CYC > CLEAR_CYC) ? RAMP_CYC : CLEAR_CYC;
    localparam int c_STEP_W   = $clog2(c_STEP_MAX + 1);

    localparam logic [c_STEP_W-1:0] c_RAMP_LAST  = c_STEP_W'(RAMP_CYC - 1);
    localparam logic [c_STEP_W-1:0] c_CLEAR_LAST = c_STEP_W'(CLEAR_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_ONE        = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_FULL       = c_CNT_W'(NBANK);

    heater_sched_state_t  r_state;
    heater_sched_state_t  w_state_nxt;
    logic [c_STEP_W-1:0]  r_cnt;
    logic [c_STEP_W-1:0]  w_cnt_nxt;
    logic [c_CNT_W-1:0]   r_active;
    logic [c_CNT_W-1:0]   w_active_nxt;
    logic [NBANK-1:0]     r_fault_bank;
    logic [NBANK-1:0]     w_fault_bank_nxt;
    logic [NBANK-1:0]     r_bank_en;
    logic [NBANK-1:0]     w_bank_en_nxt;
    logic                 r_err_clear;
    logic                 r_busy;
    logic                 r_fault;
    logic                 w_go_dn;
    logic                 w_pwm_gate;

`ifdef HEATER_SCHED_PWM_EN
    logic w_pwm_restart;

    // Counter restarts exactly on the edge that enters RUN
    assign w_pwm_restart = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);

    heater_pwm #(
        .PWM_W   (PWM_W)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_pwm_restart),
        .duty    (duty),
        .gate    (w_pwm_gate)
    );
`else
    logic w_unused_duty;

    assign w_pwm_gate    = 1'b1;
    assign w_unused_duty = ^duty;
`endif

    // Next-state, step counter, active count and fault snapshot
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_active_nxt     = r_active;
        w_fault_bank_nxt = r_fault_bank;
        w_go_dn          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_active_nxt = '0;
                w_cnt_nxt    = '0;
                if (run) begin
                    w_state_nxt  = ST_RAMP_UP;
                    w_active_nxt = c_ONE;
                end
            end
            ST_RAMP_UP: begin
                if (!run) begin
                    w_go_dn = 1'b1;
                end else if (r_cnt == c_RAMP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_active == c_FULL) begin
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_active_nxt = r_active + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!run) begin
                    w_go_dn = 1'b1;
                end else if (r_cnt == c_CLEAR_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // A bank error outranks a simultaneous run drop
                if (|bank_err) begin
                    w_state_nxt      = ST_FAULT;
                    w_active_nxt     = '0;
                    w_cnt_nxt        = '0;
                    w_fault_bank_nxt = bank_err;
                end else if (!run) begin
                    w_go_dn = 1'b1;
                end
            end
            ST_RAMP_DN: begin
                // run is deliberately not looked at until IDLE is reached
                if (r_cnt == c_RAMP_LAST) begin
                    w_cnt_nxt    = '0;
                    w_active_nxt = r_active - 1'b1;
                    if (r_active == c_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_FAULT: begin
                w_active_nxt = '0;
                w_cnt_nxt    = '0;
                if (fault_ack && !run) begin
                    w_state_nxt      = ST_IDLE;
                    w_fault_bank_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_active_nxt = '0;
                w_cnt_nxt    = '0;
            end
        endcase

        // Ramp-down entry drops one bank on the entry edge itself
        if (w_go_dn) begin
            w_cnt_nxt    = '0;
            w_active_nxt = r_active - 1'b1;
            w_state_nxt  = (r_active == c_ONE) ? ST_IDLE : ST_RAMP_DN;
        end
    end

    // Bank enables: lowest w_active_nxt banks, PWM-gated only in RUN
    always_comb begin
        w_bank_en_nxt = '0;
        for (int i = 0; i < NBANK; i++) begin
            w_bank_en_nxt[i] = (c_CNT_W'(i) < w_active_nxt) &&
                               ((w_state_nxt != ST_RUN) || w_pwm_gate);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_active     <= '0;
            r_fault_bank <= '0;
            r_bank_en    <= '0;
            r_err_clear  <= 1'b1;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_active     <= w_active_nxt;
            r_fault_bank <= w_fault_bank_nxt;
            r_bank_en    <= w_bank_en_nxt;
            r_err_clear  <= (w_state_nxt != ST_RUN);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_fault      <= (w_state_nxt == ST_FAULT);
        end
    end

    assign bank_en    = r_bank_en;
    assign err_clear  = r_err_clear;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign fault_bank = r_fault_bank;
    assign active_cnt = r_active;

endmodule
`default_nettype wire

// File: tb/tb_heater_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_heater_sched
// Description : Self-checking bench for heater_sched (NBANK=4, RAMP_CYC=8,
//               CLEAR_CYC=20, PWM_W=4). Expected outputs are queued as each
//               cycle of stimulus is applied and compared after the edge.
//               Follows HEATER_SCHED_PWM_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heater_sched;

    localparam int NBANK     = 4;
    localparam int RAMP_CYC  = 8;
    localparam int CLEAR_CYC = 20;
    localparam int PWM_W     = 4;

`ifdef HEATER_SCHED_PWM_EN
    localparam bit c_RUN_DC = 1'b1;   // RUN bank_en checked by duty counting
`else
    localparam bit c_RUN_DC = 1'b0;   // RUN bank_en must be all ones
`endif

    logic             clk;
    logic             rst_n;
    logic             run;
    logic [PWM_W-1:0] duty;
    logic             fault_ack;
    logic [NBANK-1:0] bank_err;
    logic [NBANK-1:0] bank_en;
    logic             err_clear;
    logic             busy;
    logic             fault;
    logic [NBANK-1:0] fault_bank;
    logic [2:0]       active_cnt;

    int n_checks;
    int n_fail;
    int ones;

    typedef struct {
        string      tag;
        logic [2:0] ac;
        logic [3:0] be;
        logic       ec;
        logic       bsy;
        logic       flt;
        logic [3:0] fb;
        bit         be_dc;
    } exp_t;

    exp_t exp_q[$];

    heater_sched #(
        .NBANK      (NBANK),
        .RAMP_CYC   (RAMP_CYC),
        .CLEAR_CYC  (CLEAR_CYC),
        .PWM_W      (PWM_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .duty       (duty),
        .fault_ack  (fault_ack),
        .bank_err   (bank_err),
        .bank_en    (bank_en),
        .err_clear  (err_clear),
        .busy       (busy),
        .fault      (fault),
        .fault_bank (fault_bank),
        .active_cnt (active_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int ac, input logic ec,
                                input logic bsy, input logic flt,
                                input logic [3:0] fb, input bit be_dc);
        exp_t e;
        int   m;
        m       = (1 << ac) - 1;
        e.tag   = tag;
        e.ac    = 3'(ac);
        e.be    = 4'(m);
        e.ec    = ec;
        e.bsy   = bsy;
        e.flt   = flt;
        e.fb    = fb;
        e.be_dc = be_dc;
        return e;
    endfunction

    // k = edges since the run=1 edge that enabled bank 0 (RAMP_UP/SETTLE)
    function automatic exp_t ramp_exp(input int k);
        int ac;
        ac = k / RAMP_CYC + 1;
        if (ac > NBANK) ac = NBANK;
        return mk("ramp", ac, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    endfunction

    task automatic compare_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".active_cnt"}, 32'(active_cnt), 32'(e.ac));
            check({e.tag, ".err_clear"},  32'(err_clear),  32'(e.ec));
            check({e.tag, ".busy"},       32'(busy),       32'(e.bsy));
            check({e.tag, ".fault"},      32'(fault),      32'(e.flt));
            check({e.tag, ".fault_bank"}, 32'(fault_bank), 32'(e.fb));
            if (!e.be_dc) begin
                check({e.tag, ".bank_en"}, 32'(bank_en), 32'(e.be));
            end else begin
                check({e.tag, ".bank_en_all_or_none"},
                      32'((bank_en == 4'h0) || (bank_en == 4'hF)), 32'd1);
            end
        end
    endtask

    // Apply current inputs for one edge, then compare against the expectation
    task automatic tick(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".bank_en"},    32'(bank_en),    32'h0);
        check({tag, ".active_cnt"}, 32'(active_cnt), 32'h0);
        check({tag, ".err_clear"},  32'(err_clear),  32'h1);
        check({tag, ".busy"},       32'(busy),       32'h0);
        check({tag, ".fault"},      32'(fault),      32'h0);
        check({tag, ".fault_bank"}, 32'(fault_bank), 32'h0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        run       = 1'b0;
        duty      = '0;
        fault_ack = 1'b0;
        bank_err  = '0;
        rst_n     = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) tick(mk("idle", 0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));

        // Ramp up through SETTLE into RUN
        duty = 4'd5;
        run  = 1'b1;
        for (int k = 0; k < 52; k++) tick(ramp_exp(k));

        ones = 0;
        for (int j = 0; j < 32; j++) begin
            tick(mk("run_d5", 4, 1'b0, 1'b1, 1'b0, 4'h0, c_RUN_DC));
            if (bank_en == 4'hF) ones++;
        end
`ifdef HEATER_SCHED_PWM_EN
        check("pwm_duty5_on_cycles", 32'(ones), 32'd10);
`else
        check("nopwm_on_cycles", 32'(ones), 32'd32);
`endif

        duty = 4'd0;
        ones = 0;
        for (int j = 0; j < 18; j++) begin
            tick(mk("run_d0", 4, 1'b0, 1'b1, 1'b0, 4'h0, c_RUN_DC));
            if (j >= 2 && bank_en == 4'hF) ones++;
        end
`ifdef HEATER_SCHED_PWM_EN
        check("pwm_duty0_on_cycles", 32'(ones), 32'd0);
`else
        check("nopwm_duty0_on_cycles", 32'(ones), 32'd16);
`endif

        // Fault entry, held by ack while run=1, released by ack with run=0
        bank_err = 4'b0100;
        tick(mk("flt_entry", 0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0));
        bank_err  = '0;
        fault_ack = 1'b1;
        for (int i = 0; i < 3; i++) tick(mk("flt_hold", 0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0));
        run = 1'b0;
        tick(mk("flt_exit", 0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
        fault_ack = 1'b0;
        for (int i = 0; i < 3; i++) tick(mk("idle2", 0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));

        // Drop run in SETTLE; re-assert mid ramp-down, which must be ignored
        run = 1'b1;
        for (int k = 0; k < 36; k++) tick(ramp_exp(k));
        run = 1'b0;
        for (int d = 0; d < 24; d++) begin
            if (d == 10) run = 1'b1;
            tick(mk("ramp_dn", 3 - d / RAMP_CYC, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0));
        end
        tick(mk("dn_idle", 0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));

        // Ramp restarts from IDLE because run is still high
        for (int k = 0; k < 52; k++) tick(ramp_exp(k));
        tick(mk("run2", 4, 1'b0, 1'b1, 1'b0, 4'h0, c_RUN_DC));

        // bank_err and run drop together: fault wins
        bank_err = 4'b0001;
        run      = 1'b0;
        tick(mk("prec_fault", 0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0));
        bank_err = '0;
        tick(mk("prec_hold", 0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0));
        fault_ack = 1'b1;
        tick(mk("prec_exit", 0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));
        fault_ack = 1'b0;

        // Asynchronous reset in the middle of a ramp
        run = 1'b1;
        for (int k = 0; k < 12; k++) tick(ramp_exp(k));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_ramp");
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick(mk("idle3", 0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
